// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA raster timing generator driven by pixel-rate edges from a clock divider
// Sequences the divider, steps h/v counters, decodes sync/de and fetches pixels via req/valid.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          enable,
    input  logic          flag_pixel,
    output logic          div_enable,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_start,
    output logic          pix_req,
    input  logic [DW-1:0] pix_data,
    input  logic          pix_valid,
    output logic [DW-1:0] rgb_out,
    output logic          underflow,
    output logic          busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] H_MAX      = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_MAX      = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT      = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_ACT      = YW'(V_ACTIVE);
    localparam logic [XW-1:0] H_SS       = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SE       = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_SS       = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SE       = YW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_flag_q;
    logic [XW-1:0]   r_h;
    logic [YW-1:0]   r_v;
    logic            r_de;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_frame_start;
    logic            r_pix_req;
    logic [DW-1:0]   r_rgb;
    logic            r_underflow;

    logic            w_step;
    logic            w_h_wrap;
    logic            w_frame_wrap;
    logic            w_to_idle;
    logic [XW-1:0]   w_h_nxt;
    logic [YW-1:0]   w_v_nxt;
    logic            w_de_nxt;
    logic            w_hs_nxt;
    logic            w_vs_nxt;

    assign w_step       = flag_pixel & ~r_flag_q & (r_state != S_IDLE);
    assign w_h_wrap     = (r_h == H_MAX);
    assign w_frame_wrap = w_h_wrap && (r_v == V_MAX);
    assign w_to_idle    = w_step && w_frame_wrap && (r_state == S_DRAIN);

    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (w_step) begin
            w_h_nxt = w_h_wrap ? '0 : r_h + XW'(1);
            if (w_h_wrap) begin
                w_v_nxt = (r_v == V_MAX) ? '0 : r_v + YW'(1);
            end
        end
    end

    assign w_de_nxt = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
    assign w_hs_nxt = ((w_h_nxt >= H_SS) && (w_h_nxt < H_SE)) ? SYNC_POL : ~SYNC_POL;
    assign w_vs_nxt = ((w_v_nxt >= V_SS) && (w_v_nxt < V_SE)) ? SYNC_POL : ~SYNC_POL;

    // A draining scan finishing its frame wins over a late re-enable.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_state_nxt = S_RUN;
            S_RUN:   if (!enable) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (w_to_idle) w_state_nxt = S_IDLE;
                else if (enable) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_flag_q      <= 1'b0;
            r_h           <= H_MAX;
            r_v           <= V_MAX;
            r_de          <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
            r_pix_req     <= 1'b0;
            r_rgb         <= '0;
            r_underflow   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_flag_q      <= flag_pixel;
            r_frame_start <= 1'b0;
            r_pix_req     <= 1'b0;
            if (w_to_idle) begin
                r_h     <= H_MAX;
                r_v     <= V_MAX;
                r_de    <= 1'b0;
                r_hsync <= ~SYNC_POL;
                r_vsync <= ~SYNC_POL;
            end else if (w_step) begin
                r_h           <= w_h_nxt;
                r_v           <= w_v_nxt;
                r_de          <= w_de_nxt;
                r_hsync       <= w_hs_nxt;
                r_vsync       <= w_vs_nxt;
                r_frame_start <= (r_state == S_RUN) && w_frame_wrap;
                r_pix_req     <= w_de_nxt;
            end
            // The pixel source answers in the cycle that pix_req is high.
            if (r_pix_req) begin
                r_rgb <= pix_valid ? pix_data : '0;
            end else if (!r_de) begin
                r_rgb <= '0;
            end
            if (r_frame_start) begin
                r_underflow <= 1'b0;
            end else if (r_pix_req && !pix_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign div_enable  = (r_state != S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_h;
    assign y           = r_v;
    assign frame_start = r_frame_start;
    assign pix_req     = r_pix_req;
    assign rgb_out     = r_rgb;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - scoreboard bench for vga_scan_ctrl on a reduced 8x6 raster
module tb_vga_scan_ctrl;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       enable;
    logic       flag_pixel;
    logic       div_enable;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic       pix_req;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic [7:0] rgb_out;
    logic       underflow;
    logic       busy;

    initial forever #5 clk = ~clk;

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .XW(10), .YW(10), .DW(8)
    ) dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .flag_pixel(flag_pixel),
        .div_enable(div_enable), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .frame_start(frame_start), .pix_req(pix_req),
        .pix_data(pix_data), .pix_valid(pix_valid), .rgb_out(rgb_out),
        .underflow(underflow), .busy(busy)
    );

    typedef struct {
        int         h;
        int         v;
        bit         de;
        bit         hs;
        bit         vs;
        bit         fs;
        bit         req;
        bit         busy;
        logic [7:0] rgb;
        bit         uf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference raster model: 0=idle, 1=run, 2=drain
    int         m_state = 0;
    int         m_h     = HT - 1;
    int         m_v     = VT - 1;
    logic [7:0] m_rgb   = 8'h00;
    bit         m_uf    = 1'b0;

    int steps_since_fs = 0;
    int last_gap       = 0;
    int req_in_frame   = 0;
    int last_frame_req = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_x"}, 32'(x), HT - 1);
        check_eq({tag, "_y"}, 32'(y), VT - 1);
        check_eq({tag, "_hsync"}, 32'(hsync), 1);
        check_eq({tag, "_vsync"}, 32'(vsync), 1);
        check_eq({tag, "_de"}, 32'(de), 0);
        check_eq({tag, "_pix_req"}, 32'(pix_req), 0);
        check_eq({tag, "_frame_start"}, 32'(frame_start), 0);
        check_eq({tag, "_rgb_out"}, 32'(rgb_out), 0);
        check_eq({tag, "_underflow"}, 32'(underflow), 0);
        check_eq({tag, "_div_enable"}, 32'(div_enable), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    // One pixel period: flag_pixel high 4 clks, low 4 clks; expectation pushed on the rise.
    task automatic do_step(input bit valid, input logic [7:0] data);
        exp_t e;
        bit   stepped;
        bit   wrap;
        @(posedge clk);
        #1;
        if (m_state == 0 && enable) m_state = 1;
        else if (m_state == 1 && !enable) m_state = 2;
        else if (m_state == 2 && enable) m_state = 1;
        flag_pixel = 1'b1;
        pix_valid  = valid;
        pix_data   = data;
        stepped    = (m_state != 0);
        e.fs       = 1'b0;
        if (stepped) begin
            wrap = (m_h == HT - 1) && (m_v == VT - 1);
            if (m_state == 2 && wrap) begin
                m_state = 0;
                m_h     = HT - 1;
                m_v     = VT - 1;
            end else begin
                e.fs = (m_state == 1) && wrap;
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
        end
        e.h    = m_h;
        e.v    = m_v;
        e.de   = (m_h < HA) && (m_v < VA);
        e.hs   = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
        e.vs   = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
        e.req  = stepped && e.de && (m_state != 0);
        e.busy = (m_state != 0);
        e.rgb  = e.req ? (valid ? data : 8'h00) : (e.de ? m_rgb : 8'h00);
        m_rgb  = e.rgb;
        e.uf   = e.fs ? 1'b0 : (m_uf | (e.req && !valid));
        m_uf   = e.uf;
        sb_q.push_back(e);
        repeat (4) @(posedge clk);
        #1 flag_pixel = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                #1;
                check_eq("x", 32'(x), e.h);
                check_eq("y", 32'(y), e.v);
                check_eq("de", 32'(de), 32'(e.de));
                check_eq("hsync", 32'(hsync), 32'(e.hs));
                check_eq("vsync", 32'(vsync), 32'(e.vs));
                check_eq("frame_start", 32'(frame_start), 32'(e.fs));
                check_eq("pix_req", 32'(pix_req), 32'(e.req));
                check_eq("busy", 32'(busy), 32'(e.busy));
                check_eq("div_enable", 32'(div_enable), 32'(e.busy));
                steps_since_fs++;
                if (frame_start) begin
                    last_gap       = steps_since_fs;
                    last_frame_req = req_in_frame;
                    steps_since_fs = 0;
                    req_in_frame   = 0;
                end
                if (pix_req) req_in_frame++;
                @(posedge clk);
                #1;
                check_eq("rgb_out", 32'(rgb_out), 32'(e.rgb));
                check_eq("underflow", 32'(underflow), 32'(e.uf));
                check_eq("pix_req_pulse", 32'(pix_req), 0);
                check_eq("frame_start_pulse", 32'(frame_start), 0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        n_rst      = 1'b0;
        enable     = 1'b0;
        flag_pixel = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_div_enable", 32'(div_enable), 0);

        // Start: divider enabled on the next clock, first step lands on (0,0).
        enable = 1'b1;
        @(posedge clk);
        #1;
        check_eq("start_div_enable", 32'(div_enable), 1);
        check_eq("start_busy", 32'(busy), 1);
        do_step(1'b1, 8'h11);

        // Two full frames of free run.
        for (int i = 0; i < 2 * HT * VT; i++) begin
            do_step(1'b1, 8'($urandom));
        end
        check_eq("frame_gap_steps", 32'(last_gap), HT * VT);
        check_eq("pix_req_per_frame", 32'(last_frame_req), HA * VA);

        // Known pixel, then a missing one; underflow holds until the next frame.
        do_step(1'b1, 8'hA5);
        do_step(1'b0, 8'h3C);
        for (int i = 0; i < HT * VT && !(m_h == 0 && m_v == 0); i++) begin
            do_step(1'b1, 8'($urandom));
        end
        check_eq("reach_frame_origin", 32'(m_h == 0 && m_v == 0), 1);

        // Stop request mid-frame drains to the frame end, then idles.
        for (int i = 0; i < HT * VT && !(m_h == 2 && m_v == 1); i++) begin
            do_step(1'b1, 8'($urandom));
        end
        check_eq("reach_2_1", 32'(m_h == 2 && m_v == 1), 1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < HT * VT && m_state != 0; i++) begin
            do_step(1'b1, 8'($urandom));
        end
        check_eq("drain_done", 32'(m_state), 0);
        @(posedge clk);
        #1;
        check_eq("idle_div_enable_after_drain", 32'(div_enable), 0);
        check_eq("idle_busy_after_drain", 32'(busy), 0);
        do_step(1'b1, 8'h55);
        do_step(1'b1, 8'h66);

        // Restart, then reset in the middle of a frame.
        enable = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < HT * VT && !(m_h == 3 && m_v == 2); i++) begin
            do_step(1'b1, 8'($urandom));
        end
        check_eq("reach_3_2", 32'(m_h == 3 && m_v == 2), 1);
        #1 n_rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midrst");
        m_state = 0;
        m_h     = HT - 1;
        m_v     = VT - 1;
        m_rgb   = 8'h00;
        m_uf    = 1'b0;
        n_rst   = 1'b1;
        do_step(1'b1, 8'h77);
        check_eq("restart_origin", 32'(m_h == 0 && m_v == 0), 1);

        repeat (4) @(posedge clk);
        #1;
        check_eq("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
